// File: rtl/note_sequencer.sv
// note_sequencer: table-driven melody player feeding the clock divider's divisor.
// Steps through a writable table of {divisor, beats} entries. Each entry's
// divisor is held for beats*CYCLES_PER_BEAT cycles, followed by GAP_CYCLES
// cycles with tone_en low. A divisor of 0 is a rest. A beats value of 0 marks
// the end of the song.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   start, stop           begin playback from entry 0 / abort to idle (stop wins)
//   wr_en, wr_addr,
//   wr_divisor, wr_beats  table write port, accepted in any state
//   divisor, tone_en      divisor to the clock divider, tone gate for the output stage
//   busy, done, note_idx  status: playing or in a gap, end-of-song pulse, current entry
//
// Optional feature: define NOTE_SEQUENCER_LOOP_EN to restart from entry 0 at
// the end of the song instead of pulsing done.
module note_sequencer #(
  parameter int unsigned DIV_W           = 32,
  parameter int unsigned DEPTH           = 8,
  parameter int unsigned BEAT_W          = 8,
  parameter int unsigned CYCLES_PER_BEAT = 12500000,
  parameter int unsigned GAP_CYCLES      = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DIV_W-1:0]         wr_divisor,
  input  logic [BEAT_W-1:0]        wr_beats,
  output logic [DIV_W-1:0]         divisor,
  output logic                     tone_en,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] note_idx
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CYC_W    = (CYCLES_PER_BEAT > 1) ? $clog2(CYCLES_PER_BEAT) : 1;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned CYC_LAST = CYCLES_PER_BEAT - 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned IDX_LAST = DEPTH - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DIV_W-1:0]    tbl_div_q   [DEPTH];
  logic [DIV_W-1:0]    tbl_div_d   [DEPTH];
  logic [BEAT_W-1:0]   tbl_beats_q [DEPTH];
  logic [BEAT_W-1:0]   tbl_beats_d [DEPTH];
  logic [DIV_W-1:0]    divisor_q, divisor_d;
  logic                tone_en_q, tone_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [AW-1:0]       note_idx_q, note_idx_d;
  logic [BEAT_W-1:0]   cur_beats_q, cur_beats_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [GAP_W-1:0]    gap_q, gap_d;

  logic                advance;
  logic                song_end;
  logic                do_load;
  logic                goto_done;
  logic [AW-1:0]       load_idx;
  logic [AW-1:0]       next_idx;

  // State, table and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tbl_div_q   <= '{default: '0};
      tbl_beats_q <= '{default: '0};
      divisor_q   <= '0;
      tone_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      note_idx_q  <= '0;
      cur_beats_q <= '0;
      beat_q      <= '0;
      cyc_q       <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      tbl_div_q   <= tbl_div_d;
      tbl_beats_q <= tbl_beats_d;
      divisor_q   <= divisor_d;
      tone_en_q   <= tone_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      note_idx_q  <= note_idx_d;
      cur_beats_q <= cur_beats_d;
      beat_q      <= beat_d;
      cyc_q       <= cyc_d;
      gap_q       <= gap_d;
    end
  end

  // Next-state, table update and output computation.
  always_comb begin
    state_d     = state_q;
    tbl_div_d   = tbl_div_q;
    tbl_beats_d = tbl_beats_q;
    divisor_d   = divisor_q;
    tone_en_d   = tone_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    note_idx_d  = note_idx_q;
    cur_beats_d = cur_beats_q;
    beat_d      = beat_q;
    cyc_d       = cyc_q;
    gap_d       = gap_q;
    advance     = 1'b0;
    song_end    = 1'b0;
    do_load     = 1'b0;
    goto_done   = 1'b0;
    load_idx    = '0;
    next_idx    = note_idx_q + AW'(1);

    if (wr_en) begin
      tbl_div_d[wr_addr]   = wr_divisor;
      tbl_beats_d[wr_addr] = wr_beats;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          do_load  = 1'b1;
          load_idx = '0;
        end
      end
      S_PLAY: begin
        if (cyc_q == CYC_W'(CYC_LAST)) begin
          cyc_d = '0;
          if (beat_q == (cur_beats_q - BEAT_W'(1))) begin
            beat_d = '0;
            if (GAP_CYCLES > 0) begin
              state_d   = S_GAP;
              tone_en_d = 1'b0;
              gap_d     = '0;
            end else begin
              advance = 1'b1;
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_LAST)) begin
          advance = 1'b1;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        note_idx_d = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Song ends on the last table slot or when the following entry is empty.
    if (advance) begin
      if ((note_idx_q == AW'(IDX_LAST)) || (tbl_beats_q[next_idx] == '0)) begin
        song_end = 1'b1;
      end else begin
        do_load  = 1'b1;
        load_idx = next_idx;
      end
    end

    if (song_end) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
      do_load  = 1'b1;
      load_idx = '0;
`else
      goto_done = 1'b1;
`endif
    end

    // Latch the entry so later writes cannot disturb the note in progress.
    if (do_load) begin
      if (tbl_beats_q[load_idx] == '0) begin
        goto_done = 1'b1;
      end else begin
        state_d     = S_PLAY;
        note_idx_d  = load_idx;
        divisor_d   = tbl_div_q[load_idx];
        tone_en_d   = (tbl_div_q[load_idx] != '0);
        busy_d      = 1'b1;
        cur_beats_d = tbl_beats_q[load_idx];
        cyc_d       = '0;
        beat_d      = '0;
      end
    end

    if (goto_done) begin
      state_d   = S_DONE;
      done_d    = 1'b1;
      busy_d    = 1'b0;
      tone_en_d = 1'b0;
      divisor_d = '0;
    end

    if ((state_q == S_DONE) || stop) begin
      divisor_d = '0;
      tone_en_d = 1'b0;
      busy_d    = 1'b0;
    end

    // Abort overrides everything except reset; the table is left alone.
    if (stop) begin
      state_d    = S_IDLE;
      done_d     = 1'b0;
      note_idx_d = '0;
      cyc_d      = '0;
      beat_d     = '0;
      gap_d      = '0;
    end
  end

  assign divisor  = divisor_q;
  assign tone_en  = tone_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign note_idx = note_idx_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with CYCLES_PER_BEAT=4, GAP_CYCLES=2, DEPTH=8.
// Expected per-cycle outputs come from a table model and are queued, then
// popped and compared one per clock.
module tb_note_sequencer;

  localparam int unsigned DIV_W  = 32;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned BEAT_W = 8;
  localparam int unsigned CPB    = 4;
  localparam int unsigned GAP    = 2;
  localparam int unsigned AW     = 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              stop  = 1'b0;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DIV_W-1:0]  wr_divisor = '0;
  logic [BEAT_W-1:0] wr_beats = '0;
  logic [DIV_W-1:0]  divisor;
  logic              tone_en;
  logic              busy;
  logic              done;
  logic [AW-1:0]     note_idx;

  note_sequencer #(
    .DIV_W(DIV_W), .DEPTH(DEPTH), .BEAT_W(BEAT_W),
    .CYCLES_PER_BEAT(CPB), .GAP_CYCLES(GAP)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_divisor(wr_divisor), .wr_beats(wr_beats),
    .divisor(divisor), .tone_en(tone_en), .busy(busy), .done(done), .note_idx(note_idx)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic             tone;
    logic             busy;
    logic             done;
    logic [AW-1:0]    idx;
    logic             chk_idx;
  } exp_t;

  exp_t              sb[$];
  logic [DIV_W-1:0]  tdiv  [DEPTH];
  logic [BEAT_W-1:0] tbeat [DEPTH];
  int                n_cmp = 0;
  int                n_bad = 0;
  string             tag = "init";

  function automatic exp_t mk(logic [DIV_W-1:0] d, logic t, logic b, logic dn,
                              logic [AW-1:0] i, logic ci);
    exp_t e;
    e.div = d; e.tone = t; e.busy = b; e.done = dn; e.idx = i; e.chk_idx = ci;
    return e;
  endfunction

  task automatic push_idle();
    sb.push_back(mk('0, 1'b0, 1'b0, 1'b0, '0, 1'b1));
  endtask

  task automatic push_note(int i);
    for (int k = 0; k < int'(tbeat[i]) * int'(CPB); k++)
      sb.push_back(mk(tdiv[i], tdiv[i] != '0, 1'b1, 1'b0, AW'(i), 1'b1));
    for (int k = 0; k < int'(GAP); k++)
      sb.push_back(mk(tdiv[i], 1'b0, 1'b1, 1'b0, AW'(i), 1'b1));
  endtask

  task automatic push_song();
    int i;
    i = 0;
    while (i < int'(DEPTH) && tbeat[i] != '0) begin
      push_note(i);
      i++;
    end
    sb.push_back(mk('0, 1'b0, 1'b0, 1'b1, '0, 1'b0));
    push_idle();
  endtask

  task automatic check(exp_t e);
    n_cmp++;
    assert ({divisor, tone_en, busy, done} === {e.div, e.tone, e.busy, e.done}) else begin
      n_bad++;
      $error("FAIL %s: div/tone/busy/done got %0d/%0b/%0b/%0b expected %0d/%0b/%0b/%0b",
             tag, divisor, tone_en, busy, done, e.div, e.tone, e.busy, e.done);
    end
    if (e.chk_idx) begin
      n_cmp++;
      assert (note_idx === e.idx) else begin
        n_bad++;
        $error("FAIL %s: note_idx got %0d expected %0d", tag, note_idx, e.idx);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    wr_en = 1'b0;
    if (sb.size() > 0) check(sb.pop_front());
  endtask

  task automatic drain();
    while (sb.size() > 0) cycle();
  endtask

  task automatic drive_wr(int a, logic [DIV_W-1:0] d, logic [BEAT_W-1:0] b);
    wr_en = 1'b1; wr_addr = AW'(a); wr_divisor = d; wr_beats = b;
    tdiv[a] = d; tbeat[a] = b;
  endtask

  task automatic wr_idle(int a, logic [DIV_W-1:0] d, logic [BEAT_W-1:0] b);
    drive_wr(a, d, b);
    push_idle();
    cycle();
  endtask

  task automatic clear_model();
    for (int i = 0; i < int'(DEPTH); i++) begin
      tdiv[i] = '0; tbeat[i] = '0;
    end
  endtask

  initial begin
    clear_model();

    tag = "reset";
    cycle();
    push_idle();
    cycle();
    reset = 1'b0;
    push_idle();
    cycle();

    tag = "basic_song";
    wr_idle(0, 113636, 2);
    wr_idle(1, 0, 1);
    wr_idle(2, 56818, 1);
    wr_idle(3, 123, 0);
    start = 1'b1;
    push_song();
    drain();

    tag = "empty_table";
    reset = 1'b1;
    clear_model();
    push_idle();
    cycle();
    reset = 1'b0;
    start = 1'b1;
    push_song();
    drain();

    tag = "full_table";
    for (int i = 0; i < int'(DEPTH); i++) wr_idle(i, DIV_W'(1000 + i), 1);
    start = 1'b1;
    push_song();
    drain();

    tag = "abort";
    wr_idle(0, 113636, 2);
    wr_idle(1, 0, 1);
    wr_idle(2, 56818, 1);
    wr_idle(3, 0, 0);
    start = 1'b1;
    for (int k = 0; k < 3; k++) sb.push_back(mk(113636, 1'b1, 1'b1, 1'b0, '0, 1'b1));
    cycle();
    cycle();
    drive_wr(0, 200000, 2);
    cycle();
    stop = 1'b1;
    start = 1'b1;
    push_idle();
    push_idle();
    push_idle();
    drain();

    tag = "restart";
    start = 1'b1;
    push_song();
    drain();

    tag = "reset_mid";
    start = 1'b1;
    push_note(0);
    for (int k = 0; k < int'(CPB) + 1; k++) sb.push_back(mk('0, 1'b0, 1'b1, 1'b0, AW'(1), 1'b1));
    drain();
    reset = 1'b1;
    clear_model();
    push_idle();
    cycle();
    reset = 1'b0;
    push_idle();
    cycle();
    tag = "after_reset";
    start = 1'b1;
    push_song();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
